// File: rtl/bram_sdram_emu_pkg.sv
// Shared definitions for the block-RAM SDRAM emulator: FSM encodings and data geometry.
package bram_sdram_emu_pkg;
    localparam int DATA_W = 16;
    localparam int NBYTES = 2;
    localparam int ADR_W  = 21;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;
endpackage

// File: rtl/bram_sdram_emu_bram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The read register only updates on a read, so read data is held across writes.
module bram_sp_be
    import bram_sdram_emu_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [NBYTES-1:0] i_we,
    input  logic              i_rd,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**AW];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_rdata <= '0;
        end else if (i_rd) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/bram_sdram_emu.sv
// Responder for the CPU SDRAM port backed by block RAM, with programmable wait states.
// Optional BRAMEMU_CLEAR_EN: zero the whole RAM after every reset before reporting ready.
module bram_sdram_emu
    import bram_sdram_emu_pkg::*;
#(
    parameter int AW          = 14,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk_p,
    input  logic              sdram_reset,
    input  logic              sdram_stb,
    input  logic              sdram_we,
    input  logic [1:0]        sdram_sel,
    input  logic [21:1]       sdram_adr,
    input  logic [15:0]       sdram_out,
    output logic [15:0]       sdram_dat,
    output logic              sdram_ack,
    output logic              sdram_ready
);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_reply, w_reply_next;
    logic                r_ready;
    logic                r_we;
    logic [NBYTES-1:0]   r_sel;
    logic [AW-1:0]       r_adr;
    logic [DATA_W-1:0]   r_wdat;
    logic                w_capture;
    logic [NBYTES-1:0]   w_ram_we;
    logic                w_ram_rd;
    logic [AW-1:0]       w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic                w_adr_unused;
`ifdef BRAMEMU_CLEAR_EN
    logic [AW-1:0]       r_clr_adr;
`endif

    // Upper address bits alias onto the implemented range.
    assign w_adr_unused = ^sdram_adr[21:AW+1];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_reply_next = r_reply;
        w_capture    = 1'b0;
        w_ram_we     = '0;
        w_ram_rd     = 1'b0;
        w_ram_addr   = r_adr;
        w_ram_wdata  = r_wdat;
        case (r_state)
`ifdef BRAMEMU_CLEAR_EN
            ST_CLEAR: begin
                w_ram_we    = '1;
                w_ram_addr  = r_clr_adr;
                w_ram_wdata = '0;
                if (&r_clr_adr) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (sdram_stb) begin
                    w_capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_next = ST_ACK;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!sdram_stb) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_ACK;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_ACK: begin
                if (!sdram_stb) begin
                    w_state_next = ST_IDLE;
                    w_reply_next = 1'b0;
                end else if (!r_reply) begin
                    // First edge in ACK is the one and only RAM access of the transaction.
                    w_reply_next = 1'b1;
                    if (r_we) begin
                        w_ram_we = r_sel;
                    end else begin
                        w_ram_rd = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (sdram_reset) begin
            w_ram_we = '0;
            w_ram_rd = 1'b0;
        end
    end

    always_ff @(posedge clk_p) begin
        if (sdram_reset) begin
`ifdef BRAMEMU_CLEAR_EN
            r_state   <= ST_CLEAR;
            r_ready   <= 1'b0;
            r_clr_adr <= '0;
`else
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
`endif
            r_cnt     <= '0;
            r_reply   <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_wdat    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_reply <= w_reply_next;
            if (w_capture) begin
                r_we   <= sdram_we;
                r_sel  <= sdram_sel;
                r_adr  <= sdram_adr[AW:1];
                r_wdat <= sdram_out;
            end
`ifdef BRAMEMU_CLEAR_EN
            if (r_state == ST_CLEAR) begin
                r_clr_adr <= r_clr_adr + 1'b1;
                if (&r_clr_adr) begin
                    r_ready <= 1'b1;
                end
            end
`endif
        end
    end

    bram_sp_be #(.AW(AW)) u_ram (
        .clk     (clk_p),
        .srst    (sdram_reset),
        .i_we    (w_ram_we),
        .i_rd    (w_ram_rd),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign sdram_dat   = w_ram_rdata;
    assign sdram_ack   = sdram_stb & r_reply;
    assign sdram_ready = r_ready;
endmodule

// File: tb/tb_bram_sdram_emu.sv
// Bench for bram_sdram_emu: two instances (1 and 4 wait states) checked against a transaction-level model.
module tb_bram_sdram_emu;
    localparam int AW  = 14;
    localparam int NP  = 2;
    localparam int INF = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        srst;
    logic        stb  [NP];
    logic        we   [NP];
    logic [1:0]  sel  [NP];
    logic [21:1] adr  [NP];
    logic [15:0] wdat [NP];
    logic [15:0] dat  [NP];
    logic        ack  [NP];
    logic        rdy  [NP];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_dut
            bram_sdram_emu #(.AW(AW), .WAIT_STATES((gi == 0) ? 1 : 4)) u_dut (
                .clk_p       (clk),
                .sdram_reset (srst),
                .sdram_stb   (stb[gi]),
                .sdram_we    (we[gi]),
                .sdram_sel   (sel[gi]),
                .sdram_adr   (adr[gi]),
                .sdram_out   (wdat[gi]),
                .sdram_dat   (dat[gi]),
                .sdram_ack   (ack[gi]),
                .sdram_ready (rdy[gi])
            );
        end
    endgenerate

    // Model state: expected ack start cycle, current transaction, last read value, memory contents.
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          checking = 1'b0;
    int          exp_from [NP];
    logic        t_we     [NP];
    logic [15:0] t_val    [NP];
    logic [15:0] m_last   [NP];
    logic [15:0] mm [int];

    function automatic int ws(input int p);
        return (p == 0) ? 1 : 4;
    endfunction

    function automatic int key(input int p, input logic [21:1] a);
        logic [AW-1:0] w;
        w = a[AW:1];
        return p * 65536 + int'(w);
    endfunction

    function automatic logic [15:0] mm_get(input int k);
        if (mm.exists(k)) return mm[k];
        return 16'h0000;
    endfunction

    task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s port%0d: got %h, want %h (cycle %0d)", name, p, act, exp, cyc);
        end
    endtask

    // Per-cycle compare, one time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (checking) begin
                for (int p = 0; p < NP; p++) begin
                    logic e_ack;
                    e_ack = stb[p] && (cyc >= exp_from[p]);
                    if (e_ack && !t_we[p] && cyc == exp_from[p]) m_last[p] = t_val[p];
                    chk("ack_cycle", p, {31'd0, ack[p]}, {31'd0, e_ack});
                    chk("dat_cycle", p, {16'd0, dat[p]}, {16'd0, m_last[p]});
                end
            end
        end
    end

    // Called at a falling edge; leaves the bench at the falling edge after reset release.
    task automatic reset_dut(input bit wait_ready);
        int n;
        srst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            exp_from[p] = INF;
            m_last[p]   = 16'h0000;
        end
`ifdef BRAMEMU_CLEAR_EN
        mm.delete();
`endif
        @(negedge clk);
        srst = 1'b0;
        checking = 1'b1;
        for (int p = 0; p < NP; p++) begin
            chk("reset_ack", p, {31'd0, ack[p]}, 32'd0);
            chk("reset_dat", p, {16'd0, dat[p]}, 32'h0000);
`ifdef BRAMEMU_CLEAR_EN
            chk("reset_ready", p, {31'd0, rdy[p]}, 32'd0);
`else
            chk("reset_ready", p, {31'd0, rdy[p]}, 32'd1);
`endif
            stb[p] = 1'b0;
        end
        if (wait_ready) begin
            n = 0;
            while (!rdy[0] && n < 2**AW + 20) begin
                @(negedge clk);
                n++;
            end
`ifdef BRAMEMU_CLEAR_EN
            chk("ready_delay", 0, n, 2**AW);
`else
            chk("ready_delay", 0, n, 0);
`endif
            chk("ready_both", 1, {31'd0, rdy[1]}, 32'd1);
        end
    endtask

    task automatic txn(input int p, input logic w, input logic [1:0] s, input logic [21:1] a,
                       input logic [15:0] d, input int hold, output int lat);
        int k;
        int c0;
        bit got;
        k   = key(p, a);
        got = 1'b0;
        lat = -1;
        chk("ready_before_txn", p, {31'd0, rdy[p]}, 32'd1);
        we[p] = w; sel[p] = s; adr[p] = a; wdat[p] = d;
        t_we[p]  = w;
        t_val[p] = mm_get(k);
        c0 = cyc;
        exp_from[p] = c0 + 2 + ws(p);
        stb[p] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (ack[p]) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        chk("ack_within_budget", p, {31'd0, got}, 32'd1);
        if (got && w) begin
            logic [15:0] old;
            old = mm_get(k);
            mm[k] = {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
        end
        repeat (hold) @(negedge clk);
        stb[p] = 1'b0;
        #1;
        chk("ack_drops_with_stb", p, {31'd0, ack[p]}, 32'd0);
        $display("[TB] port%0d %s adr=%h sel=%b wdata=%h rdata=%h latency=%0d",
                 p, w ? "WR" : "RD", a, s, d, dat[p], lat);
        @(negedge clk);
    endtask

    task automatic rd(input int p, input logic [21:1] a, input logic [15:0] lit, input string name);
        int lat;
        txn(p, 1'b0, 2'b11, a, 16'h0000, 0, lat);
        chk(name, p, {16'd0, dat[p]}, {16'd0, lit});
    endtask

    task automatic abort_wr(input int p, input logic [21:1] a, input logic [15:0] d, input int after);
        we[p] = 1'b1; sel[p] = 2'b11; adr[p] = a; wdat[p] = d;
        t_we[p] = 1'b1;
        exp_from[p] = cyc + 2 + ws(p);
        stb[p] = 1'b1;
        repeat (after) @(negedge clk);
        stb[p] = 1'b0;
        exp_from[p] = INF;
        $display("[TB] port%0d WR adr=%h wdata=%h aborted after %0d cycles", p, a, d, after);
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        srst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            stb[p] = 1'b0; we[p] = 1'b0; sel[p] = 2'b00; adr[p] = '0; wdat[p] = '0;
            exp_from[p] = INF; t_we[p] = 1'b0; t_val[p] = '0; m_last[p] = '0;
        end
        repeat (2) @(negedge clk);
        reset_dut(1'b1);

        // Basic write/read and latency
        txn(0, 1'b1, 2'b11, 21'h000123, 16'hA55A, 0, lat);
        chk("latency_ws1", 0, lat, 3);
        rd(0, 21'h000123, 16'hA55A, "readback_a55a");
        txn(1, 1'b1, 2'b11, 21'h000005, 16'h1111, 0, lat);
        chk("latency_ws4", 1, lat, 6);

        // Byte enables
        txn(0, 1'b1, 2'b11, 21'h000200, 16'h1234, 0, lat);
        txn(0, 1'b1, 2'b10, 21'h000200, 16'hFF00, 0, lat);
        rd(0, 21'h000200, 16'hFF34, "byte_merge");
        txn(0, 1'b1, 2'b00, 21'h000200, 16'h0000, 0, lat);
        rd(0, 21'h000200, 16'hFF34, "sel00_noop");
        txn(0, 1'b1, 2'b01, 21'h000200, 16'h00C3, 0, lat);
        rd(0, 21'h000200, 16'hFFC3, "low_byte");

        // Abort during wait states
        abort_wr(1, 21'h000005, 16'h2222, 2);
        rd(1, 21'h000005, 16'h1111, "abort_no_write");

        // Strobe held after ack
        txn(0, 1'b1, 2'b11, 21'h000300, 16'h5A5A, 5, lat);
        rd(0, 21'h000300, 16'h5A5A, "held_stb_write");
        rd(0, 21'h000123, 16'hA55A, "read_other_addr");

        // Address aliasing
        txn(0, 1'b1, 2'b11, 21'h004000, 16'hBEEF, 0, lat);
        rd(0, 21'h000000, 16'hBEEF, "alias_low");
        rd(0, 21'h1FC000, 16'hBEEF, "alias_high");

        // Reset during a pending write
        txn(0, 1'b1, 2'b11, 21'h000009, 16'h7777, 0, lat);
        we[0] = 1'b1; sel[0] = 2'b11; adr[0] = 21'h000009; wdat[0] = 16'h8888;
        t_we[0] = 1'b1;
        exp_from[0] = cyc + 3;
        stb[0] = 1'b1;
        @(negedge clk);
        reset_dut(1'b1);
`ifdef BRAMEMU_CLEAR_EN
        rd(0, 21'h000009, 16'h0000, "reset_drops_write");
`else
        rd(0, 21'h000009, 16'h7777, "reset_drops_write");
        rd(0, 21'h000123, 16'hA55A, "ram_kept_over_reset");
`endif

`ifdef BRAMEMU_CLEAR_EN
        // Clear sweep: strobe ignored, reset mid-sweep restarts it
        txn(0, 1'b1, 2'b11, 21'h000123, 16'hC0DE, 0, lat);
        reset_dut(1'b0);
        we[0] = 1'b0; sel[0] = 2'b11; adr[0] = 21'h000123; t_we[0] = 1'b0;
        stb[0] = 1'b1;
        repeat (100) @(negedge clk);
        chk("ready_low_mid_sweep", 0, {31'd0, rdy[0]}, 32'd0);
        stb[0] = 1'b0;
        @(negedge clk);
        reset_dut(1'b1);
        rd(0, 21'h000123, 16'h0000, "cleared_preload");
        rd(0, 21'h000000, 16'h0000, "cleared_first");
        rd(0, 21'h003FFF, 16'h0000, "cleared_last");
        rd(1, 21'h000005, 16'h0000, "cleared_port1");
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
